keyed_scramble_mem: RTL and testbench

Parametrised single-port data memory that stores every word scrambled under a runtime key and address. Host reads return decoded plaintext. A key change starts a sequential re-encoding engine that walks the whole array, re-scrambling each word from the old key to the new key, while host access is stalled. It sits between the core's load/store path and on-chip storage as the protected data store.

---
 rtl/keyed_scramble_pkg.sv | 46 ++++
 rtl/keyed_scramble_mem_if.sv | 33 +++
 rtl/scramble_codec.sv | 38 +++
 rtl/keyed_scramble_mem.sv | 99 +++++++++
 tb/tb_keyed_scramble_mem.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/keyed_scramble_pkg.sv
// Shared types and constants for the keyed scrambling data store.
// enc/dec here are the reference codec at the default word/key widths.
package keyed_scramble_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int KEY_W_DEFAULT  = 16;
    localparam logic [KEY_W_DEFAULT-1:0] KEY_RESET_DEFAULT = 16'h0032;
    localparam int ROT_W_DEFAULT  = $clog2(DATA_W_DEFAULT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    // Key replicated across the word, with the address folded into the low bits.
    function automatic logic [DATA_W_DEFAULT-1:0] key_mask(
        input logic [KEY_W_DEFAULT-1:0]  key,
        input logic [DATA_W_DEFAULT-1:0] addr_ext
    );
        return {(DATA_W_DEFAULT/KEY_W_DEFAULT){key}} ^ addr_ext;
    endfunction

    function automatic logic [DATA_W_DEFAULT-1:0] enc(
        input logic [DATA_W_DEFAULT-1:0] d,
        input logic [KEY_W_DEFAULT-1:0]  key,
        input logic [DATA_W_DEFAULT-1:0] addr_ext
    );
        logic [DATA_W_DEFAULT-1:0] x;
        logic [ROT_W_DEFAULT-1:0]  r;
        x = d ^ key_mask(key, addr_ext);
        r = key[ROT_W_DEFAULT-1:0];
        return (x << r) | (x >> (DATA_W_DEFAULT - int'(r)));
    endfunction

    function automatic logic [DATA_W_DEFAULT-1:0] dec(
        input logic [DATA_W_DEFAULT-1:0] s,
        input logic [KEY_W_DEFAULT-1:0]  key,
        input logic [DATA_W_DEFAULT-1:0] addr_ext
    );
        logic [ROT_W_DEFAULT-1:0] r;
        r = key[ROT_W_DEFAULT-1:0];
        return ((s >> r) | (s << (DATA_W_DEFAULT - int'(r)))) ^ key_mask(key, addr_ext);
    endfunction

endpackage

// File: rtl/keyed_scramble_mem_if.sv
// Host request/response and key-change signals of the scrambled store.
// valid/ready: a transfer happens on any rising edge where both are high; the offering side holds its payload stable until then.
interface keyed_scramble_mem_if
    import keyed_scramble_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int KEY_W  = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              key_valid;
    logic              key_ready;
    logic [KEY_W-1:0]  key_data;
    logic              busy;
    logic              rekey_done;
    state_t            fsm_state;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, key_valid, key_data,
        input  req_ready, rsp_valid, rsp_rdata, key_ready, busy, rekey_done, fsm_state
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, key_valid, key_data,
        output req_ready, rsp_valid, rsp_rdata, key_ready, busy, rekey_done, fsm_state
    );
endinterface

// File: rtl/scramble_codec.sv
// Combinational word codec: decode under dec_key and encode under enc_key, both at the same address.
// Chaining dec_out into enc_in gives an old-key to new-key re-scramble.
module scramble_codec
    import keyed_scramble_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int KEY_W  = 16,
    parameter int ADDR_W = 10
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [KEY_W-1:0]  dec_key,
    input  logic [DATA_W-1:0] dec_in,
    output logic [DATA_W-1:0] dec_out,
    input  logic [KEY_W-1:0]  enc_key,
    input  logic [DATA_W-1:0] enc_in,
    output logic [DATA_W-1:0] enc_out
);
    localparam int RW = $clog2(DATA_W);
    localparam logic [RW:0] WORD_BITS = (RW+1)'(DATA_W);

    logic [DATA_W-1:0] addr_ext;
    logic [DATA_W-1:0] dec_mask;
    logic [DATA_W-1:0] enc_mask;
    logic [DATA_W-1:0] enc_x;
    logic [RW-1:0]     dec_r;
    logic [RW-1:0]     enc_r;

    assign addr_ext = DATA_W'(addr);
    assign dec_mask = {(DATA_W/KEY_W){dec_key}} ^ addr_ext;
    assign enc_mask = {(DATA_W/KEY_W){enc_key}} ^ addr_ext;
    assign dec_r    = dec_key[RW-1:0];
    assign enc_r    = enc_key[RW-1:0];

    // A shift by the full word width yields zero, so r == 0 needs no special case.
    assign enc_x   = enc_in ^ enc_mask;
    assign enc_out = (enc_x << enc_r) | (enc_x >> (WORD_BITS - {1'b0, enc_r}));
    assign dec_out = ((dec_in >> dec_r) | (dec_in << (WORD_BITS - {1'b0, dec_r}))) ^ dec_mask;
endmodule

// File: rtl/keyed_scramble_mem.sv
// Single-port data memory stored scrambled under a runtime key and the word address.
// A key change walks the whole array re-scrambling old key to new key while host access is stalled.
module keyed_scramble_mem
    import keyed_scramble_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int KEY_W  = 16,
    parameter logic [KEY_W-1:0] KEY_RESET = KEY_W'(KEY_RESET_DEFAULT)
) (
    input logic clk,
    input logic rst,
    keyed_scramble_mem_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;

    state_t            state;
    state_t            state_next;
    logic [KEY_W-1:0]  key_cur;
    logic [KEY_W-1:0]  key_new;
    logic [ADDR_W-1:0] idx;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rekey_done_q;
    logic              req_fire;
    logic              key_fire;
    logic [DATA_W-1:0] host_enc;
    logic [DATA_W-1:0] host_dec;
    logic [DATA_W-1:0] walk_dec;
    logic [DATA_W-1:0] walk_enc;
    logic [DATA_W-1:0] mem [DEPTH];

    assign req_fire       = bus.req_valid && bus.req_ready;
    assign key_fire       = bus.key_valid && bus.key_ready;
    assign bus.req_ready  = (state == IDLE);
    assign bus.key_ready  = (state == IDLE);
    assign bus.busy       = (state == WALK);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rekey_done = rekey_done_q;
    assign bus.fsm_state  = state;

    scramble_codec #(.DATA_W(DATA_W), .KEY_W(KEY_W), .ADDR_W(ADDR_W)) u_host_codec (
        .addr    (bus.req_addr),
        .dec_key (key_cur),
        .dec_in  (mem[bus.req_addr]),
        .dec_out (host_dec),
        .enc_key (key_cur),
        .enc_in  (bus.req_wdata),
        .enc_out (host_enc)
    );

    scramble_codec #(.DATA_W(DATA_W), .KEY_W(KEY_W), .ADDR_W(ADDR_W)) u_walk_codec (
        .addr    (idx),
        .dec_key (key_cur),
        .dec_in  (mem[idx]),
        .dec_out (walk_dec),
        .enc_key (key_new),
        .enc_in  (walk_dec),
        .enc_out (walk_enc)
    );

    // Re-offering the active key skips the walk but still reports completion.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (key_fire) state_next = (bus.key_data == key_cur) ? DONE : WALK;
            WALK:    if (&idx) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            key_cur      <= KEY_RESET;
            key_new      <= KEY_RESET;
            idx          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rekey_done_q <= 1'b0;
        end else begin
            state        <= state_next;
            rsp_valid_q  <= req_fire && !bus.req_write;
            rekey_done_q <= (state == DONE);
            idx          <= (state == WALK) ? idx + 1'b1 : '0;
            if (req_fire && !bus.req_write) rsp_rdata_q <= host_dec;
            if (key_fire) key_new <= bus.key_data;
            if (state == DONE) key_cur <= key_new;
        end
    end

    // A write accepted alongside a key change lands before the walk reaches it.
    always_ff @(posedge clk) begin
        if (state == WALK) mem[idx] <= walk_enc;
        else if (req_fire && bus.req_write) mem[bus.req_addr] <= host_enc;
    end
endmodule

// File: tb/tb_keyed_scramble_mem.sv
// Directed bench for keyed_scramble_mem: vector table for plain accesses, hand sequences for re-keying and reset.
module tb_keyed_scramble_mem;
    import keyed_scramble_pkg::*;

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] data;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] exp_q[$];
    vec_t vecs[9];

    keyed_scramble_mem_if #(.DATA_W(32), .ADDR_W(10), .KEY_W(16)) bus ();
    keyed_scramble_mem_if #(.DATA_W(32), .ADDR_W(10), .KEY_W(16)) bus0 ();

    keyed_scramble_mem #(.DATA_W(32), .ADDR_W(10), .KEY_W(16), .KEY_RESET(16'h0032)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    keyed_scramble_mem #(.DATA_W(32), .ADDR_W(10), .KEY_W(16), .KEY_RESET(16'h0000)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected [TB] summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
    endtask

    task automatic host_read(input logic [9:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = a;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check({name, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        check(name, bus.rsp_rdata, exp_q.pop_front());
    endtask

    task automatic offer_key(input logic [15:0] k);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_data  = k;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while (!bus.req_ready && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        int busy_cycles;
        int ready_seen;
        int n;

        vecs[0] = '{1'b1, 10'd5,    32'hDEADBEEF, "w5"};
        vecs[1] = '{1'b0, 10'd5,    32'hDEADBEEF, "rd5"};
        vecs[2] = '{1'b1, 10'd1023, 32'hCAFEF00D, "w1023"};
        vecs[3] = '{1'b0, 10'd1023, 32'hCAFEF00D, "rd1023"};
        vecs[4] = '{1'b1, 10'd0,    32'hFFFFFFFF, "w0"};
        vecs[5] = '{1'b0, 10'd0,    32'hFFFFFFFF, "rd0"};
        vecs[6] = '{1'b1, 10'd512,  32'h00000001, "w512"};
        vecs[7] = '{1'b0, 10'd512,  32'h00000001, "rd512"};
        vecs[8] = '{1'b0, 10'd5,    32'hDEADBEEF, "rd5_again"};

        // clock / reset
        rst = 1'b1;
        bus.req_valid = 1'b0;  bus.req_write = 1'b0;  bus.req_addr = '0;  bus.req_wdata = '0;
        bus.key_valid = 1'b0;  bus.key_data  = '0;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
        bus0.key_valid = 1'b0; bus0.key_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid",  32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata",  bus.rsp_rdata, 32'd0);
        check("rst_busy",       32'(bus.busy), 32'd0);
        check("rst_rekey_done", 32'(bus.rekey_done), 32'd0);
        check("rst_req_ready",  32'(bus.req_ready), 32'd1);
        check("rst_key_ready",  32'(bus.key_ready), 32'd1);
        check("rst_state",      32'(bus.fsm_state), 32'(IDLE));
        check("rst_key_cur",    32'(dut.key_cur), 32'h0032);
        @(negedge clk);
        rst = 1'b0;

        // zero key: only the address perturbs the stored word
        @(negedge clk);
        bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_addr = 10'd5; bus0.req_wdata = 32'h0;
        @(posedge clk); #1;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0;
        check("k0_raw_mem5", dut0.mem[5], 32'h00000005);
        @(negedge clk);
        bus0.req_valid = 1'b1; bus0.req_addr = 10'd5;
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        check("k0_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
        check("k0_rsp_rdata", bus0.rsp_rdata, 32'h0);

        // vector table under the default key
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wr) host_write(vecs[i].addr, vecs[i].data);
            else            host_read(vecs[i].addr, vecs[i].data, vecs[i].name);
        end
        // rotl(DEADBEEF ^ 00320037, 18)
        check("raw_mem5", dut.mem[5], 32'hFB637A7E);

        host_write(10'd20, 32'h0BADF00D);
        check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("hold_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);

        // full walk to key 0087
        offer_key(16'h0087);
        busy_cycles = 0;
        ready_seen  = 0;
        while (bus.busy && busy_cycles < 2000) begin
            if (bus.req_ready || bus.key_ready) ready_seen = 1;
            busy_cycles++;
            @(posedge clk); #1;
        end
        check("walk_busy_cycles", 32'(busy_cycles), 32'd1024);
        check("walk_ready_low",   32'(ready_seen), 32'd0);
        check("walk_done_state",  32'(bus.fsm_state), 32'(DONE));
        check("walk_rekey_early", 32'(bus.rekey_done), 32'd0);
        @(posedge clk); #1;
        check("walk_rekey_pulse", 32'(bus.rekey_done), 32'd1);
        check("walk_key_cur",     32'(dut.key_cur), 32'h0087);
        @(posedge clk); #1;
        check("walk_rekey_once",  32'(bus.rekey_done), 32'd0);
        host_read(10'd5,    32'hDEADBEEF, "walk_rd5");
        host_read(10'd1023, 32'hCAFEF00D, "walk_rd1023");
        host_read(10'd0,    32'hFFFFFFFF, "walk_rd0");
        host_read(10'd20,   32'h0BADF00D, "walk_rd20");

        // same key again: no walk, pulse two cycles after acceptance
        offer_key(16'h0087);
        check("same_busy",        32'(bus.busy), 32'd0);
        check("same_rekey_early", 32'(bus.rekey_done), 32'd0);
        @(posedge clk); #1;
        check("same_rekey_pulse", 32'(bus.rekey_done), 32'd1);
        check("same_busy_after",  32'(bus.busy), 32'd0);
        host_read(10'd5,    32'hDEADBEEF, "same_rd5");
        host_read(10'd1023, 32'hCAFEF00D, "same_rd1023");

        // write and key change accepted in the same cycle
        @(negedge clk);
        check("both_req_ready", 32'(bus.req_ready), 32'd1);
        check("both_key_ready", 32'(bus.key_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 10'd7; bus.req_wdata = 32'h12345678;
        bus.key_valid = 1'b1; bus.key_data  = 16'h1024;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.key_valid = 1'b0;
        check("both_busy", 32'(bus.busy), 32'd1);
        wait_idle(3000, "both_walk_end");
        check("both_key_cur", 32'(dut.key_cur), 32'h1024);
        host_read(10'd7,    32'h12345678, "both_rd7");
        host_read(10'd1023, 32'hCAFEF00D, "both_rd1023");

        // reset in the middle of a walk
        offer_key(16'h0324);
        n = 0;
        while (dut.idx != 10'd300 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_idx_reached", 32'(dut.idx), 32'd300);
        rst = 1'b1;
        #1;
        check("mid_busy",      32'(bus.busy), 32'd0);
        check("mid_req_ready", 32'(bus.req_ready), 32'd1);
        check("mid_key_cur",   32'(dut.key_cur), 32'h0032);
        @(negedge clk);
        rst = 1'b0;
        host_write(10'd9, 32'hA5A5A5A5);
        host_read(10'd9, 32'hA5A5A5A5, "mid_rd9");

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
